// File: rtl/vecmac_pkg.sv
// Shared constants and FSM state type for the vector MAC sequencer family.
package vecmac_pkg;
    localparam int MAC_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int MAC_SUM_W = 18;
    localparam int CHUNK_W   = MAC_LANES * LANE_W;
    localparam int DEF_LEN_W = 16;
    localparam int DEF_ACC_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } vecmac_state_e;
endpackage

// File: rtl/vecmac_seq_ctrl_if.sv
// Command, operand stream, MAC and result signals of vecmac_seq_ctrl.
interface vecmac_seq_ctrl_if
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) ();
    logic                 start;
    logic [LEN_W-1:0]     len_chunks;
    logic                 busy;
    logic                 op_valid;
    logic                 op_ready;
    logic [CHUNK_W-1:0]   op_a;
    logic [CHUNK_W-1:0]   op_b;
    logic                 mac_in_valid;
    logic [CHUNK_W-1:0]   mac_in_a;
    logic [CHUNK_W-1:0]   mac_in_b;
    logic                 mac_out_valid;
    logic [MAC_SUM_W-1:0] mac_out_sum;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_W-1:0]     res_data;
    logic                 res_ovf;

    modport master (
        input  start, len_chunks, op_valid, op_a, op_b,
               mac_out_valid, mac_out_sum, res_ready,
        output busy, op_ready, mac_in_valid, mac_in_a, mac_in_b,
               res_valid, res_data, res_ovf
    );

    modport slave (
        output start, len_chunks, op_valid, op_a, op_b,
               mac_out_valid, mac_out_sum, res_ready,
        input  busy, op_ready, mac_in_valid, mac_in_a, mac_in_b,
               res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/vecmac_acc.sv
// Wrapping accumulator with synchronous clear and a sticky carry-out flag.
module vecmac_acc
    import vecmac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int ADD_W = MAC_SUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [ADD_W-1:0] add_val,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        sum   = {1'b0, acc_q} + SUM_W'(add_val);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_en) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/vecmac_seq_ctrl.sv
// Streams operand chunks into a 4-lane dot-product MAC and accumulates its returns.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | accepting operand chunks, one MAC issue per accepted chunk
// ST_DRAIN | all chunks issued, waiting for the remaining MAC returns
// ST_DONE  | result presented until res_ready
module vecmac_seq_ctrl
    import vecmac_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    vecmac_seq_ctrl_if.master  bus
);
    vecmac_state_e      state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic               mac_in_valid_q, mac_in_valid_d;
    logic [CHUNK_W-1:0] mac_in_a_q, mac_in_a_d;
    logic [CHUNK_W-1:0] mac_in_b_q, mac_in_b_d;
    logic               acc_clr;
    logic               ret_event;
    logic [ACC_W-1:0]   acc;
    logic               acc_ovf;

    // Returns only count while a command is in flight; strays in IDLE/DONE are dropped.
    assign ret_event = bus.mac_out_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        issue_cnt_d    = issue_cnt_q;
        ret_cnt_d      = ret_cnt_q + LEN_W'(ret_event);
        mac_in_valid_d = 1'b0;
        mac_in_a_d     = mac_in_a_q;
        mac_in_b_d     = mac_in_b_q;
        acc_clr        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_clr     = 1'b1;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    if (bus.len_chunks != '0) begin
                        len_d   = bus.len_chunks;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.op_valid) begin
                    mac_in_valid_d = 1'b1;
                    mac_in_a_d     = bus.op_a;
                    mac_in_b_d     = bus.op_b;
                    issue_cnt_d    = issue_cnt_q + LEN_W'(1);
                    if (issue_cnt_q == len_q - LEN_W'(1))
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ret_event && ret_cnt_q == len_q - LEN_W'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            mac_in_valid_q <= 1'b0;
            mac_in_a_q     <= '0;
            mac_in_b_q     <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            issue_cnt_q    <= issue_cnt_d;
            ret_cnt_q      <= ret_cnt_d;
            mac_in_valid_q <= mac_in_valid_d;
            mac_in_a_q     <= mac_in_a_d;
            mac_in_b_q     <= mac_in_b_d;
        end
    end

    vecmac_acc #(
        .ACC_W (ACC_W),
        .ADD_W (MAC_SUM_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .add_en  (ret_event),
        .add_val (bus.mac_out_sum),
        .acc     (acc),
        .ovf     (acc_ovf)
    );

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.op_ready     = (state_q == ST_ISSUE);
    assign bus.res_valid    = (state_q == ST_DONE);
    assign bus.res_data     = acc;
    assign bus.res_ovf      = acc_ovf;
    assign bus.mac_in_valid = mac_in_valid_q;
    assign bus.mac_in_a     = mac_in_a_q;
    assign bus.mac_in_b     = mac_in_b_q;
endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Randomised bench for vecmac_seq_ctrl: a 40-bit and an 18-bit build run the same commands
// against a 3-stage behavioural dot-product MAC, checked against a chunk-sum reference model.
module tb_vecmac_seq_ctrl;
    logic clk;
    logic rst_n;

    vecmac_seq_ctrl_if #(.LEN_W(16), .ACC_W(40)) bus ();
    vecmac_seq_ctrl_if #(.LEN_W(16), .ACC_W(18)) bus18 ();

    vecmac_seq_ctrl #(.LEN_W(16), .ACC_W(40)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vecmac_seq_ctrl #(.LEN_W(16), .ACC_W(18)) u_dut18 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus18)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_issue = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [17:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
        return 18'(s);
    endfunction

    // Behavioural MAC: fixed 3-cycle latency, plus an injection path for stray returns.
    logic [2:0]  pv, pv18;
    logic [17:0] ps [3];
    logic [17:0] ps18 [3];
    logic        inj_v;
    logic [17:0] inj_s;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv   <= '0;
            pv18 <= '0;
        end else begin
            pv      <= {pv[1:0], bus.mac_in_valid};
            ps[0]   <= dot4(bus.mac_in_a, bus.mac_in_b);
            ps[1]   <= ps[0];
            ps[2]   <= ps[1];
            pv18    <= {pv18[1:0], bus18.mac_in_valid};
            ps18[0] <= dot4(bus18.mac_in_a, bus18.mac_in_b);
            ps18[1] <= ps18[0];
            ps18[2] <= ps18[1];
        end
    end

    assign bus.mac_out_valid   = pv[2] | inj_v;
    assign bus.mac_out_sum     = pv[2] ? ps[2] : inj_s;
    assign bus18.mac_out_valid = pv18[2] | inj_v;
    assign bus18.mac_out_sum   = pv18[2] ? ps18[2] : inj_s;

    assign bus18.start      = bus.start;
    assign bus18.len_chunks = bus.len_chunks;
    assign bus18.op_valid   = bus.op_valid;
    assign bus18.op_a       = bus.op_a;
    assign bus18.op_b       = bus.op_b;
    assign bus18.res_ready  = bus.res_ready;

    always @(negedge clk) if (bus.mac_in_valid) n_issue++;

    // mode 0: op_valid held high, 1: toggling with start pulses while busy, 2: random bubbles
    task automatic run_cmd(input int len, input int mode, input logic [31:0] fa,
                           input logic [31:0] fb, input bit rnd, input int hold);
        logic [63:0] total = 0;
        int sent = 0;
        int cyc = 0;
        int w = 0;
        int issue0;
        logic v;
        logic [31:0] a, b;
        issue0 = n_issue;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_chunks = 16'(len);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        while (sent < len && cyc < 4 * len + 50) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            a = rnd ? $urandom : fa;
            b = rnd ? $urandom : fb;
            bus.op_valid = v;
            bus.op_a = a;
            bus.op_b = b;
            if (mode == 1 && !v) begin
                bus.start = 1'b1;
                bus.len_chunks = 16'd7;
            end else begin
                bus.start = 1'b0;
            end
            if (v && bus.op_ready) begin
                total += 64'(dot4(a, b));
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        bus.start = 1'b0;
        check("chunks_accepted", sent, len);
        if (mode == 0) check("burst_cycles", cyc, len);
        while (!bus.res_valid && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (len == 0) check("zero_len_latency", w, 0);
        check("res_valid", bus.res_valid, 1);
        check("res_data", bus.res_data, total[39:0]);
        check("res_ovf", bus.res_ovf, (total >> 40) != 0);
        check("res_data_acc18", bus18.res_data, total[17:0]);
        check("res_ovf_acc18", bus18.res_ovf, (total >> 18) != 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", bus.res_data, total[39:0]);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 0);
        check("busy_idle", bus.busy, 0);
        check("issue_pulses", n_issue - issue0, len);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len_chunks = '0;
        bus.op_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.res_ready = 1'b0;
        inj_v = 1'b0;
        inj_s = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_op_ready", bus.op_ready, 0);
        check("rst_mac_in_valid", bus.mac_in_valid, 0);
        check("rst_mac_in_a", bus.mac_in_a, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_ovf", bus.res_ovf, 0);
        rst_n = 1'b1;

        run_cmd(1, 0, 32'h04030201, 32'h08070605, 1'b0, 0);
        check("ref_dot_70", dot4(32'h04030201, 32'h08070605), 70);

        // Reset in the middle of an 8-chunk command, right after the third chunk was taken.
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_chunks = 16'd8;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a = $urandom;
            bus.op_b = $urandom;
            @(negedge clk);
        end
        bus.op_valid = 1'b0;
        check("pre_rst_mac_in_valid", bus.mac_in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_op_ready", bus.op_ready, 0);
        check("mid_rst_mac_in_valid", bus.mac_in_valid, 0);
        check("mid_rst_mac_in_a", bus.mac_in_a, 0);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_res_data", bus.res_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1, 0, 32'h01010101, 32'h01010101, 1'b0, 0);

        run_cmd(256, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        run_cmd(5, 1, 32'h0, 32'h0, 1'b1, 10);

        // Stray MAC return while idle must not leak into the following results.
        repeat (4) @(negedge clk);
        inj_s = 18'h3FFFF;
        inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        run_cmd(0, 0, 32'h0, 32'h0, 1'b0, 0);
        run_cmd(3, 2, 32'h0, 32'h0, 1'b1, 1);

        run_cmd(2, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2);

        repeat (6) run_cmd($urandom_range(1, 20), 2, 32'h0, 32'h0, 1'b1, $urandom_range(0, 4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
